// File: rtl/accum_pingpong_buffer.sv
// Ping-pong accumulation buffer: one bank accumulates partial-sum rows
// while the other is drained; banks swap on a commit/release handshake.
module accum_pingpong_buffer #(
  parameter int LANES    = 16,
  parameter int DW       = 16,
  parameter int DEPTH    = 16,
  parameter int SATURATE = 1,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wvalid,
  output logic               wready,
  input  logic [LANES*DW-1:0] wdata,
  input  logic               wr_commit,
  output logic [IW-1:0]      widx,
  output logic               ovf,
  output logic               rd_avail,
  input  logic               ren,
  input  logic [IW-1:0]      ridx,
  output logic               rvalid,
  output logic [LANES*DW-1:0] rdata,
  input  logic               rd_release
);

  typedef enum logic {ACCUM, PEND} state_t;

  state_t state, state_nxt;

  logic                sel;
  logic [DEPTH-1:0]    vld [2];
  logic [LANES*DW-1:0] mem [2][DEPTH];

  logic                wr_acc;
  logic                do_swap;
  logic [LANES*DW-1:0] old_row;
  logic [LANES*DW-1:0] new_row;
  logic [LANES-1:0]    lane_ovf;
  logic [DW:0]         op_a, op_b, sum;

  assign wr_acc = wvalid && wready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  // A commit swaps at once only when the reader has no bank,
  // or is handing it back on this very edge.
  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    unique case (state)
      ACCUM: begin
        if (wr_commit) begin
          if (!rd_avail || rd_release) do_swap   = 1'b1;
          else                         state_nxt = PEND;
        end
      end
      PEND: begin
        if (rd_release) begin
          do_swap   = 1'b1;
          state_nxt = ACCUM;
        end
      end
    endcase
  end

  always_comb begin
    wready = (state == ACCUM);
  end

  assign old_row = vld[sel][widx] ? mem[sel][widx] : '0;

  // Sign-extend by one bit; overflow shows as the top two bits differing.
  always_comb begin
    new_row  = '0;
    lane_ovf = '0;
    op_a     = '0;
    op_b     = '0;
    sum      = '0;
    for (int i = 0; i < LANES; i++) begin
      op_a = {old_row[i*DW+DW-1], old_row[i*DW +: DW]};
      op_b = {wdata[i*DW+DW-1], wdata[i*DW +: DW]};
      sum  = op_a + op_b;
      lane_ovf[i] = sum[DW] ^ sum[DW-1];
      if (lane_ovf[i] && SATURATE != 0)
        new_row[i*DW +: DW] = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                                      : {1'b0, {(DW-1){1'b1}}};
      else
        new_row[i*DW +: DW] = sum[DW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[sel][widx] <= new_row;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel      <= 1'b0;
      widx     <= '0;
      ovf      <= 1'b0;
      rd_avail <= 1'b0;
      vld[0]   <= '0;
      vld[1]   <= '0;
    end else begin
      if (wr_acc) begin
        vld[sel][widx] <= 1'b1;
        widx <= (widx == IW'(DEPTH-1)) ? '0 : widx + 1'b1;
        if (|lane_ovf) ovf <= 1'b1;
      end
      if (do_swap) begin
        sel      <= ~sel;
        rd_avail <= 1'b1;
        widx     <= '0;
        ovf      <= 1'b0;
        vld[~sel] <= '0;
      end else if (rd_release) begin
        rd_avail <= 1'b0;
      end
    end
  end

  // Uses the pre-edge sel, so a read on a swap edge sees the old bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (ren && rd_avail) begin
        rvalid <= 1'b1;
        if (int'(ridx) < DEPTH && vld[~sel][ridx])
          rdata <= mem[~sel][ridx];
        else
          rdata <= '0;
      end
    end
  end

endmodule

// File: doc/accum_pingpong_buffer.md
Name: accum_pingpong_buffer

Overview:
Parametrised double-buffered (ping-pong) accumulation buffer between the MAC array and the output/activation path. One bank accumulates LANES-wide partial-sum rows while the other bank is drained by the reader. Bank swaps use an explicit commit/release handshake. Per-row valid bits replace bulk clearing, and accumulation supports saturating or modular arithmetic.

Parameters:
LANES, 16, number of lanes per row
DW, 16, signed data width per lane
DEPTH, 16, rows per bank; any value >= 2
SATURATE, 1, 1 = saturating signed add, 0 = modulo-2^DW add
IW, $clog2(DEPTH), row index width (derived, not overridable)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous, active-low reset
wvalid  in  1  write row offered
wready  out  1  write side can accept
wdata  in  LANES*DW  signed partial sums, lane i at [i*DW +: DW]
wr_commit  in  1  pulse: current write pass complete, request swap
widx  out  IW  row the next accepted write targets
ovf  out  1  sticky: saturation/overflow occurred in current write pass
rd_avail  out  1  read bank holds committed data
ren  in  1  read request
ridx  in  IW  row to read
rvalid  out  1  rdata valid
rdata  out  LANES*DW  row read result
rd_release  in  1  pulse: reader finished with read bank

Behaviour:
- Reset values (async, immediate):
  - sel=0, so bank0 is the write bank and bank1 the read bank.
  - state=ACCUM, wready=1, widx=0, ovf=0, rd_avail=0, rvalid=0, rdata=0.
  - All row valid bits=0. Memory data is not reset.
- Write accept: wvalid && wready at the clock edge.
  - Row widx of the write bank becomes wdata if its valid bit is 0, else stored + wdata, lane-wise; the valid bit is then set.
  - widx increments and wraps DEPTH-1 -> 0. Wrapping is legal and accumulates onto existing rows.
- Arithmetic: per-lane signed DW + DW.
  - SATURATE=1: clamp to [-2^(DW-1), 2^(DW-1)-1].
  - SATURATE=0: wrap modulo 2^DW.
  - Any lane overflow sets ovf. This applies in both modes.
- FSM ACCUM (wready=1):
  - On wr_commit, a write in the same cycle is applied first.
  - If the read bank is free (rd_avail=0, or rd_release this cycle), swap at this edge.
  - Otherwise go to PEND.
- FSM PEND (wready=0, writes ignored): on rd_release, swap and return to ACCUM.
- Swap (single edge):
  - sel toggles and rd_avail=1; widx=0, ovf=0.
  - All valid bits of the new write bank clear. The old write bank keeps its valid bits for the reader.
- rd_release with rd_avail=0 is ignored. Outside a swap, rd_release clears rd_avail.
- wr_commit while in PEND is ignored. Repeated commits do not queue.
- Read, 1-cycle latency:
  - ren && rd_avail: next cycle rvalid=1 and rdata = read-bank row ridx, or zeros if that row's valid bit is 0.
  - ren && !rd_avail: rvalid=0 next cycle and rdata holds its value.
  - ridx >= DEPTH (non-power-of-2 DEPTH): rvalid=1, rdata=0.
  - rvalid is a 1-cycle pulse per accepted read.
- ren in the same cycle as rd_release or swap: served from the bank that was the read bank before that edge.
- Reads and writes always target different banks, so there is no read/write collision.
- Reset mid-operation: all control and valid bits return to reset values immediately, and in-flight data is discarded.

Test Plan:
- Fill, commit, drain: DEPTH=16, write rows 0..15 with lane value = row, then wr_commit.
  - Next cycle: rd_avail=1, widx=0.
  - ren ridx=5 -> one cycle later rvalid=1, all lanes 5.
- Accumulate with wrap: write 32 rows of all-lane 1, commit, read any row -> all lanes 2.
  - Read a never-written row after a 3-write pass -> rvalid=1, rdata 0.
- Saturation, DW=16: write 0x7000 twice to row 0.
  - SATURATE=1 -> 0x7FFF, ovf=1.
  - SATURATE=0 -> 0xE000, ovf=1.
  - -0x7000 twice, SATURATE=1 -> 0x8000.
  - ovf=0 after the next swap.
- Back-pressure: commit pass A, then commit pass B without rd_release.
  - Expect wready=0, state PEND, writes ignored.
  - Assert rd_release -> swap that edge, wready=1, rd_avail stays 1.
  - Reads now return pass B data.
- Simultaneous events:
  - wvalid+wr_commit in the same cycle -> that write is included in the committed bank.
  - ren+rd_release in the same cycle -> rvalid with old-bank data.
  - rd_release with rd_avail=0 -> no state change.
- Async reset mid-pass: assert reset_n=0 between edges -> rd_avail, rvalid, ovf, widx go to 0 immediately.
  - After release, reading a row written pre-reset (after commit of a new 1-row pass) returns zeros for other rows.
